// File: rtl/pu_interrupt_pkg.sv
// pu_interrupt_pkg: shared interrupt-controller types, Int_ctrl_reg field layout and the pin polarity helper.
package pu_interrupt_pkg;
   localparam int NUM_GIN_PINS = 4;
   typedef logic [NUM_GIN_PINS-1:0] Gin_vec;
   // Int_ctrl_reg layout: [3:0] gin_mask, [7:4] gin_sense_level, [11:8] gin_trigger, [12] doorbell_en; rest reserved
   localparam int MASK_LSB  = 0;
   localparam int SENSE_LSB = 4;
   localparam int TRIG_LSB  = 8;
   localparam int DB_EN_BIT = 12;
   function automatic Gin_vec gin_active(input Gin_vec level, input Gin_vec trigger);
      return level ^ trigger;
   endfunction
endpackage

// File: rtl/pu_gin_sync.sv
// pu_gin_sync: N-bit multi-flop synchronizer for the asynchronous gin pins.
module pu_gin_sync #(
   parameter int N      = 4,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);
   logic [STAGES-1:0][N-1:0] chain;
   always_ff @(posedge clk or negedge reset)
      if (!reset) chain <= '0;
      else        chain <= {chain[STAGES-2:0], d};
   assign q = chain[STAGES-1];
endmodule

// File: rtl/pu_ext_int_ctrl.sv
// pu_ext_int_ctrl: gin edge/level interrupt sensing with pending state, plus doorbell request handshake.
module pu_ext_int_ctrl
   import pu_interrupt_pkg::*;
#(
   parameter int NUM_GIN     = NUM_GIN_PINS,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        ctrl,
   input  logic [NUM_GIN-1:0] gin,
   input  logic [NUM_GIN-1:0] pending_clr,
   input  logic               doorbell_req,
   input  logic               doorbell_ack,
   output logic [NUM_GIN-1:0] pending,
   output logic               ext_input,
   output logic               doorbell
);
   logic [NUM_GIN-1:0] s, prev, act, pact, set, pend_nxt, mask, sense, trig;
   logic [2:0] warm;
   logic db_pending, db_en;
   logic unused_ctrl;
   assign mask        = ctrl[MASK_LSB +: NUM_GIN];
   assign sense       = ctrl[SENSE_LSB +: NUM_GIN];
   assign trig        = ctrl[TRIG_LSB +: NUM_GIN];
   assign db_en       = ctrl[DB_EN_BIT];
   assign unused_ctrl = ^ctrl[31:DB_EN_BIT+1];
   pu_gin_sync #(.N(NUM_GIN), .STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (gin),
      .q     (s)
   );
   // both act and pact use the current trigger so a trigger write alone never looks like an edge
   always_comb begin
      act      = gin_active(s, trig);
      pact     = gin_active(prev, trig);
      set      = act & ~pact & {NUM_GIN{warm == 3'd0}};
      pend_nxt = (sense & act) | (~sense & (set | (pending & ~pending_clr)));
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         prev       <= '0;
         pending    <= '0;
         warm       <= 3'(SYNC_STAGES + 1);
         db_pending <= 1'b0;
         ext_input  <= 1'b0;
         doorbell   <= 1'b0;
      end else begin
         prev       <= s;
         pending    <= pend_nxt;
         warm       <= (warm == 3'd0) ? 3'd0 : warm - 3'd1;
         db_pending <= doorbell_req | (db_pending & ~doorbell_ack);
         ext_input  <= |(pending & mask);
         doorbell   <= db_pending & db_en;
      end
endmodule

// File: doc/pu_ext_int_ctrl.md
Name: pu_ext_int_ctrl

Overview:
External-input and doorbell interrupt controller for one processing unit. It takes the Int_ctrl_reg configuration word and the asynchronous general-input pins (gin). It synchronizes the pins, applies per-pin edge/level and polarity sensing, and holds per-pin pending state. It drives the ext_input and doorbell exception requests into the core's exception unit (the Except_base fields), with an acknowledge handshake for the doorbell and software write-1-to-clear for gin pending bits.

Parameters:
NUM_GIN, 4, number of general-input pins; must match the gin_* field width of Int_ctrl_reg.
SYNC_STAGES, 2, synchronizer flops per gin pin; legal values are 2 or 3.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
ctrl  in  32  Int_ctrl_reg, quasi-static; written by software via SPR
gin  in  NUM_GIN  asynchronous external interrupt pins
pending_clr  in  NUM_GIN  one-cycle write-1-to-clear strobe for gin pending bits
doorbell_req  in  1  one-cycle doorbell message pulse
doorbell_ack  in  1  one-cycle pulse: core has taken the doorbell interrupt
pending  out  NUM_GIN  per-pin pending status, SPR-readable; unmasked
ext_input  out  1  registered external-input request to the exception unit
doorbell  out  1  registered doorbell request to the exception unit

Behaviour:
- Reset (reset=0, async): all sync flops, prev flops, pending, db_pending, ext_input and doorbell go to 0. The warm-up counter loads SYNC_STAGES+1.
- Synchronizer: gin[i] passes through SYNC_STAGES flops, giving s[i]. prev[i] holds the s[i] value from the previous cycle.
- Polarity: act[i] = s[i] XOR gin_trigger[i], and pact[i] = prev[i] XOR gin_trigger[i]. Trigger 0 means active-high / rising edge; trigger 1 means active-low / falling edge. Both act and pact use the current trigger, so a trigger change alone never creates an edge.
- Warm-up: the counter decrements each cycle to 0 and then holds. While it is nonzero, edge detection is suppressed, so a pin already asserted at reset release does not fire an edge. Level detection is not suppressed.
- Edge mode (gin_sense_level[i]=0):
  - set[i] = act[i] & ~pact[i] & warm-up done.
  - pending[i] is a sticky flop, cleared by pending_clr[i].
  - set and clr in the same cycle: set wins, so the new edge is not lost.
- Level mode (gin_sense_level[i]=1):
  - pending[i] <= act[i] every cycle; pending_clr is ignored.
  - Level to edge switch: pending keeps its current value and becomes sticky.
- Latency: gin stable before edge k gives s=1 after edge k+SYNC_STAGES-1. pending=1 follows one edge later, and ext_input=1 one edge after that. Total is SYNC_STAGES+1 edges; 3 at default.
- ext_input <= |(pending & gin_mask), registered. A mask change is reflected one cycle later. A masked pin still sets pending.
- Doorbell:
  - db_pending is set by doorbell_req and cleared by doorbell_ack.
  - req and ack in the same cycle: db_pending stays 1, so the later request survives.
  - doorbell <= db_pending & doorbell_en, registered.
  - With doorbell_en=0, requests still latch. Enabling later raises doorbell one cycle after the enable.
  - Multiple requests while pending collapse into one.
- ext_input has no ack. It stays high until software clears the pending bits (edge mode) or the pin deasserts (level mode).
- ctrl reserved bits are ignored. Reset mid-operation clears everything immediately, and the warm-up restarts.

Decomposition:
- Package Pu_interrupt gains:
  - constant NUM_GIN_PINS = 4
  - typedef Gin_vec (logic[NUM_GIN_PINS-1:0])
  - function gin_active(level, trigger) for the polarity XOR, shared with the SPR read path
- Sub-module pu_gin_sync: an N-bit, SYNC_STAGES-deep synchronizer with async active-low reset.
- The top-level block holds warm-up, edge/level logic, pending, doorbell flop and output registers.

Test Plan:
- Edge, rising: ctrl gin_mask=0001, sense=0000, trigger=0000; raise gin[0] at edge k. Required: pending=0001 after k+2, ext_input=1 after k+3. Pulse pending_clr=0001: ext_input=0 two cycles later.
- Edge, falling with set/clr collision: trigger[1]=1, mask=0010; drop gin[1] so the sync edge lands in the same cycle as pending_clr[1]=1. Required: pending[1] stays 1.
- Level: sense[2]=1, mask=0100; hold gin[2]=1 for 5 cycles with pending_clr pulsing. Required: pending[2] stays 1. Release gin[2]: pending[2]=0 and then ext_input=0 within SYNC_STAGES+1 edges.
- Masking and warm-up: gin=1111 held through reset; release reset in edge mode. Required: no pending bits set. Then raise gin[3] with mask=0000: pending=1000 and ext_input=0; set mask=1000: ext_input=1 one cycle later.
- Doorbell: doorbell_en=0, pulse doorbell_req: doorbell=0. Set en=1: doorbell=1 next cycle. Assert doorbell_ack and doorbell_req together: doorbell stays 1. Ack alone: doorbell=0 next cycle.
- Trigger flip and reset mid-operation: toggle gin_trigger[0] with gin constant in edge mode: no pending set. Pull reset low while pending=0101 and doorbell=1: all outputs 0 asynchronously.
